// File: rtl/bus_select_arb.sv
// N-to-1 channel selector with a one-entry registered output stage.
// Channels are picked by the select input (MODE=0) or by round-robin arbitration (MODE=1).
module bus_select_arb #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 2,
    parameter int MODE  = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [(2**SEL_W)*WIDTH-1:0]     in_data,
    input  logic [(2**SEL_W)-1:0]           in_valid,
    output logic [(2**SEL_W)-1:0]           in_ready,
    input  logic [SEL_W-1:0]                select,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SEL_W-1:0]                out_sel
);

    localparam int NUM_IN = 2**SEL_W;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   grant;
    logic [SEL_W-1:0]   idx;
    logic               found;
    logic               can_accept;
    logic               any_valid;
    logic               xfer;

    assign out_valid  = (state == FULL);
    assign can_accept = !out_valid | out_ready;
    assign any_valid  = |in_valid;

    // Round-robin search starts one past the last winner; the final step
    // (k = NUM_IN) wraps back onto ptr itself so a lone requester always wins.
    always_comb begin
        grant = select;
        found = 1'b0;
        idx   = '0;
        if (MODE == 1) begin
            grant = '0;
            for (int k = 1; k <= NUM_IN; k++) begin
                idx = ptr + SEL_W'(k);
                if (!found && in_valid[idx]) begin
                    grant = idx;
                    found = 1'b1;
                end
            end
        end
    end

    // rst_n gates in_ready so no handshake is offered while reset is held.
    always_comb begin
        in_ready = '0;
        if (rst_n && can_accept && (MODE == 0 || any_valid)) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign xfer = in_valid[grant] & in_ready[grant];

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            state_nxt = FULL;
        end else if (out_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_sel  <= '0;
        end else if (xfer) begin
            out_data <= in_data[grant*WIDTH +: WIDTH];
            out_sel  <= grant;
        end
    end

    // Reset value NUM_IN-1 gives channel 0 first priority after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= SEL_W'(NUM_IN - 1);
        end else if (MODE == 1 && xfer) begin
            ptr <= grant;
        end
    end

endmodule

// File: tb/tb_bus_select_arb.sv
// Bench for bus_select_arb: one instance per mode, shared stimulus, compared
// every cycle against a behavioural model of the output register and arbiter.
module tb_bus_select_arb;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [63:0]      in_data = '0;
    logic [3:0]       in_valid = '0;
    logic [1:0]       select = '0;
    logic             out_ready = 1'b0;
    logic [1:0][3:0]  in_ready_w;
    logic [1:0][15:0] out_data_w;
    logic [1:0]       out_valid_w;
    logic [1:0][1:0]  out_sel_w;

    int checks = 0;
    int errors = 0;

    int          m_valid [2];
    int          m_sel   [2];
    int          m_ptr   [2];
    logic [15:0] m_data  [2];

    always #5 clk = ~clk;

    bus_select_arb #(.WIDTH(16), .SEL_W(2), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_w[0]), .select(select), .out_data(out_data_w[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_sel(out_sel_w[0])
    );

    bus_select_arb #(.WIDTH(16), .SEL_W(2), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_w[1]), .select(select), .out_data(out_data_w[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_sel(out_sel_w[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_grant(input int mode, input int ptr);
        if (mode == 0) return int'(select);
        for (int k = 1; k <= 4; k++) begin
            if (in_valid[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [15:0] chan(input int g);
        return 16'(in_data >> (16 * g));
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0;
            m_sel[m]   = 0;
            m_ptr[m]   = 3;
            m_data[m]  = '0;
        end
    endtask

    // Checks at the falling edge, then advances the model across the rising edge.
    task automatic tick();
        int          g;
        logic [3:0]  er;
        int          n_valid [2];
        int          n_sel   [2];
        int          n_ptr   [2];
        logic [15:0] n_data  [2];
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            g  = ref_grant(m, m_ptr[m]);
            er = (rst_n && g >= 0 && (m_valid[m] == 0 || out_ready)) ? 4'(1 << g) : 4'b0;
            check_eq($sformatf("in_ready_m%0d", m), 32'(in_ready_w[m]), 32'(er));
            check_eq($sformatf("out_valid_m%0d", m), 32'(out_valid_w[m]), 32'(m_valid[m]));
            check_eq($sformatf("out_data_m%0d", m), 32'(out_data_w[m]), 32'(m_data[m]));
            check_eq($sformatf("out_sel_m%0d", m), 32'(out_sel_w[m]), 32'(m_sel[m]));
            n_valid[m] = m_valid[m];
            n_sel[m]   = m_sel[m];
            n_ptr[m]   = m_ptr[m];
            n_data[m]  = m_data[m];
            if (er != 4'b0 && in_valid[g]) begin
                n_valid[m] = 1;
                n_sel[m]   = g;
                n_data[m]  = chan(g);
                if (m == 1) n_ptr[m] = g;
            end else if (out_ready) begin
                n_valid[m] = 0;
            end
        end
        @(posedge clk);
        if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
                m_valid[m] = n_valid[m];
                m_sel[m]   = n_sel[m];
                m_ptr[m]   = n_ptr[m];
                m_data[m]  = n_data[m];
            end
        end
        #1;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("rst_valid_m%0d", m), 32'(out_valid_w[m]), 32'd0);
            check_eq($sformatf("rst_data_m%0d", m), 32'(out_data_w[m]), 32'd0);
            check_eq($sformatf("rst_sel_m%0d", m), 32'(out_sel_w[m]), 32'd0);
            check_eq($sformatf("rst_ready_m%0d", m), 32'(in_ready_w[m]), 32'd0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_fair [6];
        int exp_sparse [4];
        exp_fair   = '{0, 1, 2, 3, 0, 1};
        exp_sparse = '{1, 3, 1, 3};
        model_reset();

        // Reset held with active inputs: everything must stay quiet.
        in_valid  = 4'hF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("init_valid_m%0d", m), 32'(out_valid_w[m]), 32'd0);
            check_eq($sformatf("init_data_m%0d", m), 32'(out_data_w[m]), 32'd0);
            check_eq($sformatf("init_sel_m%0d", m), 32'(out_sel_w[m]), 32'd0);
            check_eq($sformatf("init_ready_m%0d", m), 32'(in_ready_w[m]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic select path.
        select    = 2'd2;
        in_valid  = 4'b0100;
        in_data   = 64'h0000_BEEF_0000_0000;
        out_ready = 1'b1;
        #3;
        check_eq("basic_ready", 32'(in_ready_w[0]), 32'h4);
        tick();
        check_eq("basic_valid", 32'(out_valid_w[0]), 32'd1);
        check_eq("basic_data", 32'(out_data_w[0]), 32'hBEEF);
        check_eq("basic_sel", 32'(out_sel_w[0]), 32'd2);

        // Backpressure: hold 16'h1234 while select and data churn.
        select   = 2'd0;
        in_valid = 4'b0001;
        in_data  = 64'h0000_0000_0000_1234;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            select   = 2'($urandom);
            in_data  = {$urandom, $urandom};
            in_valid = 4'($urandom);
            tick();
            check_eq("bp_hold_data", 32'(out_data_w[0]), 32'h1234);
            check_eq("bp_hold_sel", 32'(out_sel_w[0]), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 4'hF;
        select    = 2'd3;
        in_data   = 64'h5A5A_0000_0000_0000;
        tick();
        check_eq("bp_refill_valid", 32'(out_valid_w[0]), 32'd1);
        check_eq("bp_refill_data", 32'(out_data_w[0]), 32'h5A5A);

        // Selected channel not valid: no transfer even with others valid.
        in_valid = 4'b0000;
        tick();
        select   = 2'd1;
        in_valid = 4'b1101;
        tick();
        tick();
        check_eq("empty_ch_valid", 32'(out_valid_w[0]), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            select    = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Reset mid-stream, then round-robin fairness from channel 0.
        in_valid  = 4'hF;
        out_ready = 1'b1;
        async_reset();
        for (int i = 0; i < 6; i++) begin
            in_data = {$urandom, $urandom};
            tick();
            check_eq($sformatf("fair_sel_%0d", i), 32'(out_sel_w[1]), 32'(exp_fair[i]));
        end

        // Sparse requests alternate between channels 1 and 3.
        in_valid = 4'b1010;
        async_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("sparse_sel_%0d", i), 32'(out_sel_w[1]), 32'(exp_sparse[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_select_arb.md
BUS_SELECT_ARB -- requirements
Module: bus_select_arb

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width of every channel and of the output.
REQ-002 Parameter SEL_W, default 2, SHALL set the select width; NUM_IN = 2**SEL_W channels (default 4).
REQ-003 Parameter MODE, default 0, SHALL choose the channel-selection mode: 0 = select-driven, 1 = round-robin arbitration.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_data  input  NUM_IN*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  NUM_IN  per-channel data-valid.
REQ-009 in_ready  output  NUM_IN  per-channel accept; at most one bit high in any cycle.
REQ-010 select  input  SEL_W  channel index; used only when MODE=0.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds an untaken word.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_sel  output  SEL_W  index of the channel that produced out_data.

Function
REQ-015 The output stage SHALL be a one-entry register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 can_accept = !out_valid | out_ready; it SHALL be computed combinationally.
REQ-017 The granted channel g SHALL be chosen combinationally each cycle: MODE=0 -> g=select; MODE=1 -> the first i with in_valid[i]=1, searching upward from (ptr+1) mod NUM_IN.
REQ-018 in_ready[g] SHALL equal can_accept, gated in MODE=1 by "some in_valid is high"; every other in_ready bit SHALL be 0.
REQ-019 A transfer SHALL occur when in_valid[g] & in_ready[g]; on the next clk edge out_data <= channel g data, out_sel <= g, out_valid <= 1.
REQ-020 Latency SHALL be 1 cycle, from a transfer to out_valid with that data.
REQ-021 Sustained throughput SHALL be 1 word/cycle while out_ready=1.
REQ-022 FULL -> EMPTY SHALL occur when out_ready=1 and no transfer occurs in that cycle.
REQ-023 FULL with out_ready=1 and a simultaneous transfer SHALL stay FULL with the new word (drain and refill in one cycle).
REQ-024 FULL with out_ready=0 SHALL hold out_data and out_sel stable, with all in_ready at 0.
REQ-025 In MODE=0, in_valid[select]=0 SHALL produce no transfer, even if other channels are valid.
REQ-026 Changing select while FULL SHALL NOT alter out_data or out_sel.
REQ-027 In MODE=1, ptr (SEL_W bits) SHALL load g on each transfer only, wrapping NUM_IN-1 -> 0.
REQ-028 In MODE=1, ptr SHALL hold when there is no transfer.
REQ-029 In MODE=1 with a single valid channel, that channel SHALL be granted on every accept cycle, regardless of ptr.
REQ-030 In MODE=0, ptr SHALL be unused and SHALL remain at its reset value.

Reset
REQ-031 While rst_n=0: out_valid=0, out_data=0, out_sel=0, ptr=NUM_IN-1 (so channel 0 has first priority), and in_ready=0 regardless of inputs.
REQ-032 Reset assertion SHALL take effect immediately, without a clk edge.
REQ-033 Reset mid-transfer SHALL discard the held word; no transfer SHALL complete in the reset cycle.
REQ-034 The first transfer after reset SHALL be possible on the first rising clk edge after rst_n deasserts.

Verification
REQ-035 MODE=0 basic path: select=2, in_valid=4'b0100, ch2 data=16'hBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=16'hBEEF, out_sel=2.
REQ-036 MODE=0 backpressure: FULL with 16'h1234 and out_ready=0 for 5 cycles while select and in_data change -> out_data stays 16'h1234 and in_ready=0 throughout; on out_ready=1 with ch valid -> drain and refill in the same cycle.
REQ-037 MODE=1 fairness: all in_valid=1, out_ready=1 from reset -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles.
REQ-038 MODE=1 sparse requests: in_valid=4'b1010, ptr=1 -> grant 3, then 1, then 3; ptr wraps 3 -> 0 on the search.
REQ-039 MODE=0 empty channel: select=1, in_valid=4'b1101 -> no transfer; out_valid remains 0.
REQ-040 Async reset: assert rst_n=0 mid-stream between clk edges -> out_valid, out_data, out_sel and in_ready all 0 immediately; after release, ch0 is granted first in MODE=1.
